// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the async ROM and registers one word per fetch for decode.
// Latency: first word valid 2 edges after start/branch. Backpressure: instr_ready=0 holds the word and stops ROM reads.
module instr_fetch_ctrl #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 20,
  parameter int ROM_DEPTH = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_ce,
  output logic              rom_read_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_req,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, HALTED} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              instr_valid_q;
  logic              halted_q;
  logic              fault_q;
  logic              fetch_en;
  logic              target_ok;

  // A ROM read happens only when the word it returns will be captured at this edge.
  assign fetch_en    = ((state_q == FETCH) || ((state_q == VALID) && instr_ready))
                       && !branch_valid && !halt_req;
  assign target_ok   = branch_target < ADDR_W'(ROM_DEPTH);
  assign pc_d        = (pc_q == ADDR_W'(ROM_DEPTH - 1)) ? '0 : pc_q + ADDR_W'(1);

  assign rom_addr    = pc_q;
  assign rom_ce      = fetch_en;
  assign rom_read_en = fetch_en;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_q <= FETCH;
        end
        HALTED: begin
          if (start) begin
            state_q  <= FETCH;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
          end
        end
        FETCH, VALID: begin
          if (branch_valid) begin
            instr_valid_q <= 1'b0;
            if (target_ok) begin
              pc_q    <= branch_target;
              state_q <= FETCH;
            end else begin
              fault_q  <= 1'b1;
              halted_q <= 1'b1;
              state_q  <= HALTED;
            end
          end else if (halt_req) begin
            // A held word must still transfer before halting.
            if (state_q == FETCH || instr_ready) begin
              instr_valid_q <= 1'b0;
              halted_q      <= 1'b1;
              state_q       <= HALTED;
            end
          end else if (fetch_en) begin
            instr_q       <= rom_data;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            pc_q          <= pc_d;
            state_q       <= VALID;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl; ROM word at address a holds a+1.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] rom_addr;
  logic        rom_ce;
  logic        rom_read_en;
  logic [19:0] rom_data;
  logic [19:0] instr;
  logic [19:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_valid;
  logic [19:0] branch_target;
  logic        halt_req;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;
  logic [39:0] sb[$];

  instr_fetch_ctrl #(.ADDR_W(20), .DATA_W(20), .ROM_DEPTH(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_ce(rom_ce), .rom_read_en(rom_read_en), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .halt_req(halt_req), .halted(halted), .fault(fault)
  );

  assign rom_data = (rom_ce && rom_addr < 20'd7) ? rom_addr + 20'd1 : 20'hBAD00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int pc);
    sb.push_back({20'(pc), 20'(pc + 1)});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_instr"}, instr, 0);
    chk({tag, "_ipc"}, instr_pc, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_ce"}, rom_ce, 0);
    chk({tag, "_rden"}, rom_read_en, 0);
    chk({tag, "_addr"}, rom_addr, 0);
  endtask

  // Transfer monitor: a word moves to decode when valid & ready and no flush.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !branch_valid) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_xfer: observed pc %0h data %0h expected no transfer", instr_pc, instr);
      end
      if (sb.size() > 0) chk("xfer", {instr_pc, instr}, sb.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
    branch_valid = 1'b0; branch_target = '0; halt_req = 1'b0;
    tick(); tick();
    chk_reset("rst");

    // Streaming with wrap-around.
    rst_n = 1'b1; start = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 7; i++) push(i);
    push(0); push(1); push(2);
    tick();
    start = 1'b0;
    chk("e1_valid", instr_valid, 0);
    chk("e1_ce", rom_ce, 1);
    chk("e1_rden", rom_read_en, 1);
    tick();
    chk("e2_valid", instr_valid, 1);
    chk("e2_instr", instr, 20'h00001);
    chk("e2_ipc", instr_pc, 0);
    repeat (7) tick();
    chk("wrap_ipc", instr_pc, 0);
    chk("wrap_instr", instr, 20'h00001);
    tick(); tick();
    chk("bp_ipc", instr_pc, 2);

    // Backpressure for 3 cycles.
    instr_ready = 1'b0;
    #1 chk("bp_ce0", rom_ce, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_instr", instr, 20'h00003);
      chk("bp_hold_ipc", instr_pc, 2);
      chk("bp_hold_ce", rom_ce, 0);
    end
    instr_ready = 1'b1;
    push(3); push(4); push(5); push(6); push(0);
    tick();
    chk("bp_next_instr", instr, 20'h00004);
    chk("bp_next_ipc", instr_pc, 3);
    repeat (5) tick();
    chk("br_pre_ipc", instr_pc, 1);

    // Good branch while word at pc 1 is held.
    instr_ready = 1'b0; branch_valid = 1'b1; branch_target = 20'd5;
    #1 chk("br_ce", rom_ce, 0);
    tick();
    branch_valid = 1'b0; instr_ready = 1'b1;
    chk("br_flush", instr_valid, 0);
    #1 chk("br_fetch_ce", rom_ce, 1);
    chk("br_fetch_addr", rom_addr, 5);
    push(5);
    tick();
    chk("br_valid", instr_valid, 1);
    chk("br_ipc", instr_pc, 5);
    chk("br_instr", instr, 20'h00006);
    tick();
    chk("br_next_ipc", instr_pc, 6);

    // Out-of-range branch.
    instr_ready = 1'b0; branch_valid = 1'b1; branch_target = 20'd9;
    #1 chk("bad_ce", rom_ce, 0);
    tick();
    branch_valid = 1'b0;
    chk("bad_fault", fault, 1);
    chk("bad_halted", halted, 1);
    chk("bad_valid", instr_valid, 0);
    #1 chk("bad_ce_after", rom_ce, 0);
    chk("bad_pc_kept", rom_addr, 0);
    tick();
    chk("bad_fault_sticky", fault, 1);
    chk("bad_halted_stay", halted, 1);
    start = 1'b1;
    #1 chk("bad_start_ce", rom_ce, 0);
    tick();
    start = 1'b0; instr_ready = 1'b1;
    chk("resume_fault_clr", fault, 0);
    chk("resume_halted_clr", halted, 0);
    #1 chk("resume_ce", rom_ce, 1);
    chk("resume_addr", rom_addr, 0);
    push(0);
    tick();
    chk("resume_ipc", instr_pc, 0);
    chk("resume_instr", instr, 20'h00001);

    // Halt with the word held for 2 cycles.
    instr_ready = 1'b0; halt_req = 1'b1;
    #1 chk("halt_ce", rom_ce, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("halt_wait_halted", halted, 0);
      chk("halt_wait_valid", instr_valid, 1);
      chk("halt_wait_ipc", instr_pc, 0);
    end
    instr_ready = 1'b1;
    #1 chk("halt_xfer_ce", rom_ce, 0);
    tick();
    chk("halt_halted", halted, 1);
    chk("halt_valid", instr_valid, 0);
    halt_req = 1'b0;
    tick();
    chk("halt_stay", halted, 1);
    chk("halt_stay_ce", rom_ce, 0);
    chk("halt_pc", rom_addr, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("halt_resume", halted, 0);
    push(1);
    tick();
    chk("halt_resume_ipc", instr_pc, 1);
    chk("halt_resume_instr", instr, 20'h00002);
    tick();

    // Mid-stream reset.
    rst_n = 1'b0;
    tick();
    chk_reset("mid_rst");
    rst_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    push(0);
    tick();
    chk("post_rst_ipc", instr_pc, 0);
    chk("post_rst_instr", instr, 20'h00001);
    tick();
    instr_ready = 1'b0;
    tick();
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
